// File: rtl/xm23_alu.sv
// XM23 ALU: combines D and S under alu_op into a result and updated PSW, registered (1-cycle latency).
// No backpressure: a new operation is accepted on every clock edge, with no handshake.
module xm23_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_bus,
    input  logic [WIDTH-1:0] s_bus,
    input  logic [5:0]       alu_op,
    input  logic [WIDTH-1:0] psw_in,
    input  logic             psw_update,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_psw_out
);

    localparam logic [15:0] PSW_RESET = 16'h60E0;

    logic [4:0]  op;
    logic        byte_m;
    logic        c_in;
    logic        sub_op;
    logic        cin;
    logic [15:0] b_op;
    logic [16:0] sum_w;
    logic [8:0]  sum_b;
    logic [4:0]  nib;
    logic        dc;
    logic        dc_b;
    logic [15:0] bcd;
    logic [15:0] res;
    logic [15:0] fr;
    logic        upd_zn;
    logic        upd_c;
    logic        upd_v;
    logic        new_c;
    logic        new_v;
    logic        msb;
    logic        zero;
    logic [15:0] out_n;
    logic [15:0] psw_n;

    always_comb begin
        op     = alu_op[4:0];
        // SWPB and SXT are inherently word operations
        byte_m = alu_op[5] && (op != 5'd15) && (op != 5'd16);
        c_in   = psw_in[0];

        sub_op = (op == 5'd2) || (op == 5'd3) || (op == 5'd5);
        b_op   = sub_op ? ~s_bus : s_bus;
        if (op == 5'd0)
            cin = 1'b0;
        else if ((op == 5'd2) || (op == 5'd5))
            cin = 1'b1;
        else
            cin = c_in;
        sum_w = {1'b0, d_bus} + {1'b0, b_op} + {16'b0, cin};
        sum_b = {1'b0, d_bus[7:0]} + {1'b0, b_op[7:0]} + {8'b0, cin};

        // BCD add: a nibble sum above 9 gets +6; low 4 bits stay correct even if nib wraps
        dc   = c_in;
        dc_b = 1'b0;
        bcd  = '0;
        nib  = '0;
        for (int i = 0; i < 4; i++) begin
            nib = {1'b0, d_bus[4*i +: 4]} + {1'b0, s_bus[4*i +: 4]} + {4'b0, dc};
            if (nib > 5'd9) begin
                nib = nib + 5'd6;
                dc  = 1'b1;
            end else begin
                dc  = 1'b0;
            end
            bcd[4*i +: 4] = nib[3:0];
            if (i == 1) dc_b = dc;
        end

        res    = d_bus;
        fr     = d_bus;
        upd_zn = 1'b0;
        upd_c  = 1'b0;
        upd_v  = 1'b0;
        new_c  = c_in;
        new_v  = 1'b0;

        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd5: begin
                fr     = byte_m ? {8'h00, sum_b[7:0]} : sum_w[15:0];
                res    = (op == 5'd5) ? d_bus : fr;
                upd_zn = 1'b1;
                upd_c  = 1'b1;
                upd_v  = 1'b1;
                new_c  = byte_m ? sum_b[8] : sum_w[16];
                new_v  = byte_m ? ((d_bus[7] == b_op[7]) && (fr[7] != d_bus[7]))
                                : ((d_bus[15] == b_op[15]) && (fr[15] != d_bus[15]));
            end
            5'd4: begin
                fr     = bcd;
                res    = bcd;
                upd_zn = 1'b1;
                upd_c  = 1'b1;
                new_c  = byte_m ? dc_b : dc;
            end
            5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd16: begin
                case (op)
                    5'd6:    fr = d_bus ^ s_bus;
                    5'd7:    fr = d_bus & s_bus;
                    5'd9:    fr = d_bus & s_bus;
                    5'd10:   fr = d_bus & ~s_bus;
                    5'd16:   fr = {{8{d_bus[7]}}, d_bus[7:0]};
                    default: fr = d_bus | s_bus;
                endcase
                res    = (op == 5'd9) ? d_bus : fr;
                upd_zn = 1'b1;
                upd_v  = 1'b1;
            end
            5'd12: begin
                fr  = s_bus;
                res = s_bus;
            end
            5'd13, 5'd14: begin
                if (op == 5'd13)
                    fr = byte_m ? {8'h00, d_bus[7], d_bus[7:1]} : {d_bus[15], d_bus[15:1]};
                else
                    fr = byte_m ? {8'h00, c_in, d_bus[7:1]} : {c_in, d_bus[15:1]};
                res    = fr;
                upd_zn = 1'b1;
                upd_c  = 1'b1;
                upd_v  = 1'b1;
                new_c  = d_bus[0];
            end
            5'd15: begin
                fr  = {d_bus[7:0], d_bus[15:8]};
                res = fr;
            end
            default: begin
                fr  = d_bus;
                res = d_bus;
            end
        endcase

        out_n = byte_m ? {d_bus[15:8], res[7:0]} : res;
        msb   = byte_m ? fr[7] : fr[15];
        zero  = byte_m ? (fr[7:0] == 8'h00) : (fr == 16'h0000);

        psw_n = psw_in;
        if (psw_update) begin
            if (upd_zn) begin
                psw_n[1] = zero;
                psw_n[2] = msb;
            end
            if (upd_c) psw_n[0] = new_c;
            if (upd_v) psw_n[4] = new_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out     <= '0;
            alu_psw_out <= PSW_RESET;
        end else begin
            alu_out     <= out_n;
            alu_psw_out <= psw_n;
        end
    end

endmodule

// File: tb/tb_xm23_alu.sv
// Vector-table bench for xm23_alu; expected results queue up when driven and are checked one cycle later.
module tb_xm23_alu;

    typedef struct {
        string       name;
        logic [15:0] d;
        logic [15:0] s;
        logic [5:0]  op;
        logic [15:0] psw;
        logic        upd;
        logic [15:0] exp_out;
        logic [15:0] exp_psw;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic [15:0] psw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_bus = '0;
    logic [15:0] s_bus = '0;
    logic [5:0]  alu_op = '0;
    logic [15:0] psw_in = '0;
    logic        psw_update = 1'b0;
    logic [15:0] alu_out;
    logic [15:0] alu_psw_out;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];
    exp_t sb[$];

    xm23_alu #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_bus      (d_bus),
        .s_bus      (s_bus),
        .alu_op     (alu_op),
        .psw_in     (psw_in),
        .psw_update (psw_update),
        .alu_out    (alu_out),
        .alu_psw_out(alu_psw_out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic [15:0] d, logic [15:0] s, logic [5:0] op,
                                logic [15:0] psw, logic upd, logic [15:0] eo, logic [15:0] ep);
        vec_t v;
        v.name = name; v.d = d; v.s = s; v.op = op; v.psw = psw; v.upd = upd;
        v.exp_out = eo; v.exp_psw = ep;
        return v;
    endfunction

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        n_checks++;
        if (alu_out !== e.out) begin
            n_fail++;
            $display("FAIL %s alu_out: got %h expected %h", e.name, alu_out, e.out);
        end
        n_checks++;
        if (alu_psw_out !== e.psw) begin
            n_fail++;
            $display("FAIL %s alu_psw_out: got %h expected %h", e.name, alu_psw_out, e.psw);
        end
    endtask

    // One cycle: check what the previous cycle produced, then drive the next op
    task automatic cycle(input logic r, input vec_t v);
        exp_t e;
        @(negedge clk);
        check_head();
        rst        = r;
        d_bus      = v.d;
        s_bus      = v.s;
        alu_op     = v.op;
        psw_in     = v.psw;
        psw_update = v.upd;
        e.name = r ? {"reset_during_", v.name} : v.name;
        e.out  = r ? 16'h0000 : v.exp_out;
        e.psw  = r ? 16'h60E0 : v.exp_psw;
        sb.push_back(e);
    endtask

    initial begin
        //            name          D        S        op      psw_in   upd   out      psw
        vecs.push_back(mk("add_w_ovf",   16'h7FFF, 16'h0001, 6'h00, 16'h60E0, 1, 16'h8000, 16'h60F4));
        vecs.push_back(mk("sub_w_eq",    16'h0005, 16'h0005, 6'h02, 16'h60E0, 1, 16'h0000, 16'h60E3));
        vecs.push_back(mk("cmp_w_eq",    16'h0005, 16'h0005, 6'h05, 16'h60E0, 1, 16'h0005, 16'h60E3));
        vecs.push_back(mk("add_b_wrap",  16'h12FF, 16'h0001, 6'h20, 16'h60E0, 1, 16'h1200, 16'h60E3));
        vecs.push_back(mk("dadd_w",      16'h0999, 16'h0001, 6'h04, 16'h60E0, 1, 16'h1000, 16'h60E0));
        vecs.push_back(mk("rrc_w",       16'h0001, 16'h0000, 6'h0E, 16'h60E1, 1, 16'h8000, 16'h60E5));
        vecs.push_back(mk("add_noupd",   16'h0001, 16'h0002, 6'h00, 16'h1234, 0, 16'h0003, 16'h1234));
        vecs.push_back(mk("op20_pass",   16'hABCD, 16'h1111, 6'h14, 16'h60E0, 1, 16'hABCD, 16'h60E0));
        vecs.push_back(mk("add_w_wrap",  16'hFFFF, 16'h0001, 6'h00, 16'h60E0, 1, 16'h0000, 16'h60E3));
        vecs.push_back(mk("addc_w",      16'h0001, 16'h0001, 6'h01, 16'h60E1, 1, 16'h0003, 16'h60E0));
        vecs.push_back(mk("subc_w",      16'h0005, 16'h0003, 6'h03, 16'h60E0, 1, 16'h0001, 16'h60E1));
        vecs.push_back(mk("sub_b_ovf",   16'hAB80, 16'h0001, 6'h22, 16'h60E0, 1, 16'hAB7F, 16'h60F1));
        vecs.push_back(mk("xor_w",       16'hF0F0, 16'hFF00, 6'h06, 16'h60F1, 1, 16'h0FF0, 16'h60E1));
        vecs.push_back(mk("and_w_zero",  16'hF0F0, 16'h0F0F, 6'h07, 16'h60E0, 1, 16'h0000, 16'h60E2));
        vecs.push_back(mk("or_w",        16'h8000, 16'h0001, 6'h08, 16'h60E0, 1, 16'h8001, 16'h60E4));
        vecs.push_back(mk("bit_w",       16'h8001, 16'h8000, 6'h09, 16'h60F0, 1, 16'h8001, 16'h60E4));
        vecs.push_back(mk("bic_w",       16'hFFFF, 16'h00FF, 6'h0A, 16'h60E0, 1, 16'hFF00, 16'h60E4));
        vecs.push_back(mk("bis_w",       16'h1200, 16'h0034, 6'h0B, 16'h60E0, 1, 16'h1234, 16'h60E0));
        vecs.push_back(mk("mov_w",       16'h1111, 16'hBEEF, 6'h0C, 16'h60E0, 1, 16'hBEEF, 16'h60E0));
        vecs.push_back(mk("sra_w",       16'h8003, 16'h0000, 6'h0D, 16'h60E0, 1, 16'hC001, 16'h60E5));
        vecs.push_back(mk("sra_b",       16'h1281, 16'h0000, 6'h2D, 16'h60E0, 1, 16'h12C0, 16'h60E5));
        vecs.push_back(mk("swpb_bbit",   16'h1234, 16'h0000, 6'h2F, 16'h60E0, 1, 16'h3412, 16'h60E0));
        vecs.push_back(mk("sxt_bbit",    16'hAB80, 16'h0000, 6'h30, 16'h60F1, 1, 16'hFF80, 16'h60E5));
        vecs.push_back(mk("dadd_b",      16'hAB99, 16'h0001, 6'h24, 16'h60E0, 1, 16'hAB00, 16'h60E3));
        vecs.push_back(mk("psw_opaque",  16'h0001, 16'h0001, 6'h00, 16'hFFFF, 1, 16'h0002, 16'hFFE8));
        vecs.push_back(mk("addc_b_ovf",  16'h007F, 16'h0000, 6'h21, 16'h60E1, 1, 16'h0080, 16'h60F4));

        // Reset state, held over two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (alu_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected 0000", alu_out);
        end
        n_checks++;
        if (alu_psw_out !== 16'h60E0) begin
            n_fail++;
            $display("FAIL reset_psw: got %h expected 60e0", alu_psw_out);
        end

        // Back-to-back vectors, one per cycle
        foreach (vecs[i]) cycle(1'b0, vecs[i]);

        // Reset arriving with an ADD in flight discards it; the next op lands one cycle later
        cycle(1'b1, vecs[0]);
        cycle(1'b0, vecs[1]);
        cycle(1'b0, vecs[3]);

        @(negedge clk);
        check_head();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
